// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit FSM states, error codes, framing
// constants and the byte-wise reflected CRC-32 step.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_IPG      = 3'd7
    } eth_tx_state_t;

    typedef enum logic [1:0] {
        ERR_OK        = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERSIZE  = 2'b10
    } eth_err_t;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ ETH_CRC_POLY;
            end else begin
                c = (c >> 1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered byte-wise IEEE 802.3 CRC-32 accumulator (reflected, preset to
// all ones); shared between the transmit framer and the receive checker.
module eth_crc32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    import eth_pkg::*;

    // CRC register: preset on init, fold in one byte per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 32'hFFFFFFFF;
        end else if (init) begin
            crc <= 32'hFFFFFFFF;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/eth_mac_tx_mq.sv
// Multi-queue GMII transmit framer: round-robin queue grant, preamble/SFD,
// payload, zero pad, CRC-32 FCS, inter-packet gap, underflow/oversize abort.
module eth_mac_tx_mq #(
    parameter int NUM_Q     = 4,
    parameter int IPG_BYTES = 12,
    parameter int MIN_BYTES = 60,
    parameter int MAX_BYTES = 1514
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_Q*8-1:0]   s_tdata,
    input  logic [NUM_Q-1:0]     s_tvalid,
    input  logic [NUM_Q-1:0]     s_tlast,
    output logic [NUM_Q-1:0]     s_tready,
    input  logic [NUM_Q-1:0]     q_enable,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic                 tx_done,
    output logic [((NUM_Q > 1) ? $clog2(NUM_Q) : 1)-1:0] tx_done_q,
    output logic [15:0]          tx_len,
    output logic [1:0]           tx_err_code
);
    import eth_pkg::*;

    localparam int          QW       = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam logic [15:0] MIN_W    = 16'(MIN_BYTES);
    localparam logic [15:0] MAX_W    = 16'(MAX_BYTES);
    localparam logic [15:0] IPG_LAST = 16'(IPG_BYTES - 1);

    eth_tx_state_t state_r, state_s;
    eth_err_t      err_r, err_s;
    logic [QW-1:0] grant_r, grant_s, last_grant_r, last_grant_s;
    logic [QW-1:0] pick_s, idx_s, done_q_r, done_q_s;
    logic          pick_found_s;
    logic [NUM_Q-1:0] req_s;
    logic [15:0]   cnt_r, cnt_s, byte_cnt_r, byte_cnt_s, len_r, len_s;
    logic [7:0]    txd_r, txd_s, data_s, fcs_byte_s, crc_data_s;
    logic          tx_en_r, tx_en_s, tx_er_r, tx_er_s, done_r, done_s;
    logic [1:0]    code_r, code_s;
    logic          valid_s, last_s, take_s, crc_init_s, crc_en_s;
    logic [31:0]   crc_s, fcs_word_s;

    eth_crc32 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init_s),
        .en    (crc_en_s),
        .data  (crc_data_s),
        .crc   (crc_s)
    );

    assign take_s = (state_r == ST_DATA) || (state_r == ST_DRAIN);

    // Round-robin search starting one past the last granted queue
    always_comb begin
        req_s        = q_enable & s_tvalid;
        pick_found_s = 1'b0;
        pick_s       = '0;
        idx_s        = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            idx_s = QW'((int'(last_grant_r) + k) % NUM_Q);
            if (!pick_found_s && req_s[idx_s]) begin
                pick_found_s = 1'b1;
                pick_s       = idx_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Select the granted queue's stream and steer its ready
    always_comb begin
        data_s   = 8'h00;
        valid_s  = 1'b0;
        last_s   = 1'b0;
        s_tready = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (grant_r == QW'(i)) begin
                data_s      = s_tdata[i*8 +: 8];
                valid_s     = s_tvalid[i];
                last_s      = s_tlast[i];
                s_tready[i] = take_s;
            end else begin
                s_tready[i] = 1'b0;
            end
        end
    end

    // FCS goes out complemented, least significant byte first
    always_comb begin
        fcs_word_s = ~crc_s;
        case (cnt_r[1:0])
            2'd0:    fcs_byte_s = fcs_word_s[7:0];
            2'd1:    fcs_byte_s = fcs_word_s[15:8];
            2'd2:    fcs_byte_s = fcs_word_s[23:16];
            2'd3:    fcs_byte_s = fcs_word_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Next-state logic; *_s outputs describe the byte driven next cycle
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        byte_cnt_s   = byte_cnt_r;
        err_s        = err_r;
        txd_s        = 8'h00;
        tx_en_s      = 1'b0;
        tx_er_s      = 1'b0;
        done_s       = 1'b0;
        done_q_s     = done_q_r;
        len_s        = len_r;
        code_s       = code_r;
        crc_init_s   = 1'b0;
        crc_en_s     = 1'b0;
        crc_data_s   = 8'h00;
        case (state_r)
            ST_IDLE: begin
                crc_init_s = 1'b1;
                byte_cnt_s = 16'd0;
                err_s      = ERR_OK;
                if (pick_found_s) begin
                    grant_s      = pick_s;
                    last_grant_s = pick_s;
                    cnt_s        = 16'd0;
                    txd_s        = ETH_PREAMBLE;
                    tx_en_s      = 1'b1;
                    state_s      = ST_PREAMBLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                txd_s   = ETH_PREAMBLE;
                tx_en_s = 1'b1;
                if (cnt_r == 16'd5) begin
                    cnt_s   = 16'd0;
                    state_s = ST_SFD;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_SFD: begin
                txd_s   = ETH_SFD;
                tx_en_s = 1'b1;
                state_s = ST_DATA;
            end
            ST_DATA: begin
                byte_cnt_s = byte_cnt_r + 16'd1;
                tx_en_s    = 1'b1;
                cnt_s      = 16'd0;
                if (!valid_s) begin
                    tx_er_s = 1'b1;
                    err_s   = ERR_UNDERFLOW;
                    state_s = ST_DRAIN;
                end else if (byte_cnt_r == MAX_W) begin
                    // byte MAX_BYTES+1 is itself replaced by the error marker
                    tx_er_s = 1'b1;
                    err_s   = ERR_OVERSIZE;
                    state_s = last_s ? ST_IPG : ST_DRAIN;
                end else begin
                    txd_s      = data_s;
                    crc_en_s   = 1'b1;
                    crc_data_s = data_s;
                    if (last_s) begin
                        state_s = (byte_cnt_s < MIN_W) ? ST_PAD : ST_FCS;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
            end
            ST_PAD: begin
                tx_en_s    = 1'b1;
                crc_en_s   = 1'b1;
                byte_cnt_s = byte_cnt_r + 16'd1;
                if (byte_cnt_s == MIN_W) begin
                    cnt_s   = 16'd0;
                    state_s = ST_FCS;
                end else begin
                    state_s = ST_PAD;
                end
            end
            ST_FCS: begin
                txd_s   = fcs_byte_s;
                tx_en_s = 1'b1;
                if (cnt_r == 16'd3) begin
                    cnt_s   = 16'd0;
                    state_s = ST_IPG;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (valid_s && last_s) begin
                    cnt_s   = 16'd0;
                    state_s = ST_IPG;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_IPG: begin
                if (cnt_r == 16'd0) begin
                    done_s   = 1'b1;
                    done_q_s = grant_r;
                    len_s    = byte_cnt_r;
                    code_s   = err_r;
                end else begin
                    done_s = 1'b0;
                end
                if (cnt_r == IPG_LAST) begin
                    cnt_s   = 16'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered GMII/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            err_r        <= ERR_OK;
            grant_r      <= '0;
            last_grant_r <= QW'(NUM_Q - 1);
            cnt_r        <= 16'd0;
            byte_cnt_r   <= 16'd0;
            txd_r        <= 8'h00;
            tx_en_r      <= 1'b0;
            tx_er_r      <= 1'b0;
            done_r       <= 1'b0;
            done_q_r     <= '0;
            len_r        <= 16'd0;
            code_r       <= 2'b00;
        end else begin
            state_r      <= state_s;
            err_r        <= err_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            byte_cnt_r   <= byte_cnt_s;
            txd_r        <= txd_s;
            tx_en_r      <= tx_en_s;
            tx_er_r      <= tx_er_s;
            done_r       <= done_s;
            done_q_r     <= done_q_s;
            len_r        <= len_s;
            code_r       <= code_s;
        end
    end

    assign gmii_txd    = txd_r;
    assign gmii_tx_en  = tx_en_r;
    assign gmii_tx_er  = tx_er_r;
    assign tx_done     = done_r;
    assign tx_done_q   = done_q_r;
    assign tx_len      = len_r;
    assign tx_err_code = code_r;

endmodule

// File: tb/tb_eth_mac_tx_mq.sv
// Directed bench for eth_mac_tx_mq: per-queue byte sources, a GMII wire log,
// and an independent bit-serial CRC model for expected frames.
module tb_eth_mac_tx_mq;
    localparam int NQ = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NQ*8-1:0] s_tdata;
    logic [NQ-1:0]   s_tvalid, s_tlast, s_tready, q_enable;
    logic [7:0]      gmii_txd;
    logic            gmii_tx_en, gmii_tx_er, tx_done;
    logic [1:0]      tx_done_q;
    logic [15:0]     tx_len;
    logic [1:0]      tx_err_code;

    eth_mac_tx_mq #(.NUM_Q(NQ), .IPG_BYTES(12), .MIN_BYTES(60), .MAX_BYTES(1514)) dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .q_enable(q_enable),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .tx_done(tx_done), .tx_done_q(tx_done_q), .tx_len(tx_len), .tx_err_code(tx_err_code)
    );

    always #4 clk = ~clk;

    typedef struct { int cyc; logic er; logic [7:0] d; } wire_t;
    typedef struct { int q; int len; int code; } done_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [9:0]  src_q [NQ][$];   // bit9 = one-cycle hole, bit8 = last
    wire_t       wire_log[$];
    done_t       done_log[$];
    int          fr_s[$], fr_e[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h00000000);
        end
        return r;
    endfunction

    // Source driver: present at negedge, retire accepted bytes just before posedge
    initial begin
        s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        forever begin
            @(negedge clk);
            for (int q = 0; q < NQ; q++) begin
                if (src_q[q].size() > 0 && src_q[q][0][9]) begin
                    void'(src_q[q].pop_front());
                    s_tvalid[q] = 1'b0; s_tlast[q] = 1'b0;
                end else if (src_q[q].size() > 0) begin
                    s_tvalid[q] = 1'b1;
                    s_tlast[q]  = src_q[q][0][8];
                    s_tdata[q*8 +: 8] = src_q[q][0][7:0];
                end else begin
                    s_tvalid[q] = 1'b0; s_tlast[q] = 1'b0;
                end
            end
            #3;
            for (int q = 0; q < NQ; q++)
                if (s_tvalid[q] && s_tready[q] && src_q[q].size() > 0) void'(src_q[q].pop_front());
        end
    end

    // Wire monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (gmii_tx_en) wire_log.push_back('{cyc, gmii_tx_er, gmii_txd});
            if (tx_done) done_log.push_back('{int'(tx_done_q), int'(tx_len), int'(tx_err_code)});
        end
    end

    task automatic load_frame(input int q, input int n, input logic [7:0] base, input int hole_after);
        for (int i = 0; i < n; i++) begin
            src_q[q].push_back({1'b0, (i == n - 1), 8'(base + 8'(i))});
            if (hole_after > 0 && i == hole_after - 1) src_q[q].push_back(10'h200);
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check("wait_done", done_log.size(), n);
    endtask

    task automatic split_frames();
        fr_s.delete(); fr_e.delete();
        for (int i = 0; i < wire_log.size(); i++) begin
            if (i == 0 || wire_log[i].cyc != wire_log[i-1].cyc + 1) begin
                fr_s.push_back(i);
                if (i > 0) fr_e.push_back(i - 1);
            end
        end
        if (wire_log.size() > 0) fr_e.push_back(wire_log.size() - 1);
    endtask

    task automatic clear_logs();
        wire_log.delete(); done_log.delete();
    endtask

    // Expected frame: preamble, SFD, payload base+i, zero pad to 60, FCS
    task automatic check_good_frame(input string tag, input int k, input int n, input logic [7:0] base);
        logic [7:0]  exp_b[$];
        logic [31:0] c;
        int          len_obs, bad;
        for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < ((n < 60) ? 60 : n); i++) begin
            exp_b.push_back((i < n) ? 8'(base + 8'(i)) : 8'h00);
            c = tb_crc(c, exp_b[exp_b.size() - 1]);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) exp_b.push_back(c[8*i +: 8]);
        len_obs = (k < fr_s.size()) ? fr_e[k] - fr_s[k] + 1 : 0;
        bad = 0;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len_obs && i < exp_b.size(); i++) begin
            if (wire_log[fr_s[k] + i].d !== exp_b[i] || wire_log[fr_s[k] + i].er !== 1'b0) bad++;
            if (i >= 8) c = tb_crc(c, wire_log[fr_s[k] + i].d);
        end
        check({tag, "_txen_cycles"}, len_obs, exp_b.size());
        check({tag, "_bytes_bad"}, bad, 0);
        check({tag, "_crc_residue"}, c, 32'hDEBB20E3);
    endtask

    task automatic check_abort_frame(input string tag, input int k, input int ngood, input logic [7:0] base);
        int len_obs, bad;
        logic [7:0] e;
        len_obs = (k < fr_s.size()) ? fr_e[k] - fr_s[k] + 1 : 0;
        bad = 0;
        for (int i = 0; i < len_obs; i++) begin
            e = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : (i < 8 + ngood) ? 8'(base + 8'(i - 8)) : 8'h00;
            if (wire_log[fr_s[k] + i].d !== e || wire_log[fr_s[k] + i].er !== (i == 8 + ngood)) bad++;
        end
        check({tag, "_txen_cycles"}, len_obs, 9 + ngood);
        check({tag, "_bytes_bad"}, bad, 0);
    endtask

    task automatic check_done(input string tag, input int k, input int q, input int len, input int code);
        check({tag, "_done_q"},    (k < done_log.size()) ? done_log[k].q    : -1, q);
        check({tag, "_done_len"},  (k < done_log.size()) ? done_log[k].len  : -1, len);
        check({tag, "_done_code"}, (k < done_log.size()) ? done_log[k].code : -1, code);
    endtask

    initial begin
        int k, gap;
        q_enable = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_tx_en", gmii_tx_en, 1'b0);
        check("rst_tx_er", gmii_tx_er, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_tready", s_tready, 4'h0);
        check("rst_tx_len", tx_len, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 64-byte frame 0x00..0x3F on queue 0
        load_frame(0, 64, 8'h00, 0);
        wait_done(1, 400);
        split_frames();
        check("f64_frames", fr_s.size(), 1);
        check_good_frame("f64", 0, 64, 8'h00);
        check_done("f64", 0, 0, 64, 0);
        clear_logs();

        // 1-byte frame padded to 60
        load_frame(0, 1, 8'hAB, 0);
        wait_done(1, 400);
        split_frames();
        check_good_frame("f1", 0, 1, 8'hAB);
        check_done("f1", 0, 0, 60, 0);
        clear_logs();

        // four queues, three frames each; last grant was queue 0
        for (int f = 0; f < 3; f++)
            for (int q = 0; q < NQ; q++) load_frame(q, 10 + q, 8'(q * 64 + f * 16), 0);
        wait_done(12, 1500);
        split_frames();
        check("rr_frames", fr_s.size(), 12);
        for (int j = 0; j < 12; j++) begin
            check_good_frame($sformatf("rr%0d", j), j, 10 + (j + 1) % 4, 8'(((j + 1) % 4) * 64 + (j / 4) * 16));
            check_done($sformatf("rr%0d", j), j, (j + 1) % 4, 60, 0);
        end
        for (int j = 0; j < 11; j++) begin
            gap = (j + 1 < fr_s.size()) ? wire_log[fr_s[j+1]].cyc - wire_log[fr_e[j]].cyc - 1 : -1;
            check($sformatf("rr_gap%0d", j), gap, 12);
        end
        clear_logs();

        // underflow after 20 bytes on queue 2
        load_frame(2, 40, 8'h80, 20);
        wait_done(1, 400);
        split_frames();
        check("uf_frames", fr_s.size(), 1);
        check_abort_frame("uf", 0, 20, 8'h80);
        check_done("uf", 0, 2, 21, 1);
        check("uf_drained", src_q[2].size(), 0);
        clear_logs();

        // maximum legal frame
        load_frame(1, 1514, 8'h11, 0);
        wait_done(1, 2000);
        split_frames();
        check_good_frame("max", 0, 1514, 8'h11);
        check_done("max", 0, 1, 1514, 0);
        clear_logs();

        // oversize 1600-byte frame with q_enable toggled mid-frame
        load_frame(3, 1600, 8'h22, 0);
        repeat (200) @(negedge clk);
        q_enable = 4'h0;
        repeat (30) @(negedge clk);
        q_enable = 4'hF;
        wait_done(1, 2200);
        split_frames();
        check("ov_frames", fr_s.size(), 1);
        check_abort_frame("ov", 0, 1514, 8'h22);
        check_done("ov", 0, 3, 1515, 2);
        check("ov_drained", src_q[3].size(), 0);
        clear_logs();

        // reset asserted during FCS
        load_frame(0, 64, 8'h40, 0);
        k = 0;
        while (wire_log.size() < 73 && k < 400) begin
            @(negedge clk); #1; k++;
        end
        check("rst_reached_fcs", wire_log.size() >= 73, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", gmii_txd, 8'h00);
        check("mid_rst_tx_en", gmii_tx_en, 1'b0);
        check("mid_rst_tx_er", gmii_tx_er, 1'b0);
        check("mid_rst_tready", s_tready, 4'h0);
        check("mid_rst_tx_len", tx_len, 16'd0);
        check("mid_rst_err_code", tx_err_code, 2'b00);
        repeat (2) @(negedge clk);
        for (int q = 0; q < NQ; q++) src_q[q].delete();
        clear_logs();
        rst_n = 1'b1;
        load_frame(1, 20, 8'h60, 0);
        load_frame(0, 61, 8'hA0, 0);
        wait_done(2, 500);
        split_frames();
        check_good_frame("post_rst_q0", 0, 61, 8'hA0);
        check_done("post_rst_q0", 0, 0, 61, 0);
        check_good_frame("post_rst_q1", 1, 20, 8'h60);
        check_done("post_rst_q1", 1, 1, 60, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
